// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if -- request/response bundle for the ALU execute stage.
//
// Signals:
//   start         : request, accepted when busy is low
//   alu_operation : class code from main control
//   function_code : R-format funct field
//   operand_a     : rs value
//   operand_b     : rt value or immediate
//   shamt         : shift amount
//   busy          : multi-cycle operation in progress
//   done          : one-cycle pulse, result and flags valid
//   result        : low result word
//   result_hi     : high product word (0 for non-multiply ops)
//   zero          : result == 0
//   overflow      : signed overflow on add/sub
//
// Modports: master (issuer, e.g. control FSM) and slave (the ALU).
interface alu_exec_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [2:0]       alu_operation;
    logic [5:0]       function_code;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             overflow;

    modport master (
        output start, alu_operation, function_code, operand_a, operand_b, shamt,
        input  busy, done, result, result_hi, zero, overflow
    );

    modport slave (
        input  start, alu_operation, function_code, operand_a, operand_b, shamt,
        output busy, done, result, result_hi, zero, overflow
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- EX-stage ALU with registered results.
//
// Decodes alu_operation / function_code at accept. add, sub, and, or, slt
// (and shifts by 0) complete at the accepting edge; shifts run one bit per
// cycle; the optional signed multiply runs as an iterative shift-add on
// operand magnitudes followed by a sign-correction cycle.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : alu_exec_unit_if.slave (start/busy/done handshake, operands,
//           result, result_hi, zero, overflow)
//
// Build option: define ALU_EXEC_MUL_EN to compile the multiplier (funct
// 011000). Without it that funct decodes as add and result_hi is constant 0.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic clk,
    input  logic reset,
    alu_exec_unit_if.slave bus
);

    // Counter holds either a shift amount or the multiply iteration count.
    localparam int CNT_W = (SHW > $clog2(WIDTH + 1)) ? SHW : $clog2(WIDTH + 1);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
        OP_SLL, OP_SRL, OP_SRA, OP_MUL
    } op_t;

`ifdef ALU_EXEC_MUL_EN
    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t             state, state_n;
    op_t                dec_op, op_r;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   work;        // shift operand, or multiplier low half
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               ovf_q;
    logic               done_q;

    logic               accept;
    logic               is_shift;
    logic [WIDTH-1:0]   sum, diff;
    logic [WIDTH-1:0]   alu_val;
    logic               alu_ovf;
    logic [WIDTH-1:0]   sh_val;
    logic               fin;
    logic [WIDTH-1:0]   fin_lo;
    logic               fin_ovf;

`ifdef ALU_EXEC_MUL_EN
    logic [WIDTH-1:0]   mul_a;       // |operand_a|
    logic [WIDTH-1:0]   mul_hi;      // product high half (magnitude)
    logic               mul_neg;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   result_hi_q;
`endif

    assign accept = bus.start && (state == IDLE);

    // ---------------------------------------------------------------- decode
    always_comb begin
        dec_op = OP_ADD;
        case (bus.alu_operation)
            3'b001: dec_op = OP_SUB;
            3'b101: dec_op = OP_AND;
            3'b111: dec_op = OP_OR;
            3'b010: begin
                case (bus.function_code)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b101010: dec_op = OP_SLT;
                    6'b000000: dec_op = OP_SLL;
                    6'b000010: dec_op = OP_SRL;
                    6'b000011: dec_op = OP_SRA;
`ifdef ALU_EXEC_MUL_EN
                    6'b011000: dec_op = OP_MUL;
`endif
                    default:   dec_op = OP_ADD;
                endcase
            end
            default: dec_op = OP_ADD;
        endcase
    end

    assign is_shift = (dec_op == OP_SLL) || (dec_op == OP_SRL) || (dec_op == OP_SRA);

    // ------------------------------------------------------- single-cycle ops
    assign sum  = bus.operand_a + bus.operand_b;
    assign diff = bus.operand_a - bus.operand_b;

    always_comb begin
        alu_val = sum;
        alu_ovf = 1'b0;
        case (dec_op)
            OP_SUB: begin
                alu_val = diff;
                alu_ovf = (bus.operand_a[WIDTH-1] != bus.operand_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.operand_a[WIDTH-1]);
            end
            OP_AND: alu_val = bus.operand_a & bus.operand_b;
            OP_OR:  alu_val = bus.operand_a | bus.operand_b;
            OP_SLT: alu_val = {{(WIDTH-1){1'b0}},
                               ($signed(bus.operand_a) < $signed(bus.operand_b))};
            OP_SLL, OP_SRL, OP_SRA: alu_val = bus.operand_a;  // shamt == 0
            default: begin
                alu_val = sum;
                alu_ovf = (bus.operand_a[WIDTH-1] == bus.operand_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.operand_a[WIDTH-1]);
            end
        endcase
    end

    // ---------------------------------------------------------- shift step
    always_comb begin
        case (op_r)
            OP_SLL:  sh_val = work << 1;
            OP_SRL:  sh_val = work >> 1;
            default: sh_val = {work[WIDTH-1], work[WIDTH-1:1]};
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    // ------------------------------------------------------- multiply step
    assign mag_a    = bus.operand_a[WIDTH-1] ? ('0 - bus.operand_a) : bus.operand_a;
    assign mag_b    = bus.operand_b[WIDTH-1] ? ('0 - bus.operand_b) : bus.operand_b;
    assign mul_sum  = {1'b0, mul_hi} + (work[0] ? {1'b0, mul_a} : '0);
    assign prod_mag = {mul_hi, work};
    assign prod     = mul_neg ? ('0 - prod_mag) : prod_mag;
`endif

    // ------------------------------------------------------ state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_shift && (bus.shamt != '0)) state_n = SHIFT;
`ifdef ALU_EXEC_MUL_EN
                    if (dec_op == OP_MUL) state_n = MUL;
`endif
                end
            end
            SHIFT: if (cnt == CNT_W'(1)) state_n = IDLE;
`ifdef ALU_EXEC_MUL_EN
            MUL:   if (cnt == '0) state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        fin     = 1'b0;
        fin_lo  = alu_val;
        fin_ovf = 1'b0;
`ifdef ALU_EXEC_MUL_EN
        fin_hi  = '0;
`endif
        case (state)
            IDLE: begin
                fin     = accept && (state_n == IDLE);
                fin_lo  = alu_val;
                fin_ovf = alu_ovf;
            end
            SHIFT: begin
                fin    = (cnt == CNT_W'(1));
                fin_lo = sh_val;
            end
`ifdef ALU_EXEC_MUL_EN
            MUL: begin
                fin    = (cnt == '0);
                fin_lo = prod[WIDTH-1:0];
                fin_hi = prod[2*WIDTH-1:WIDTH];
            end
`endif
            default: fin = 1'b0;
        endcase
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            cnt      <= '0;
            work     <= '0;
            op_r     <= OP_ADD;
`ifdef ALU_EXEC_MUL_EN
            result_hi_q <= '0;
            mul_a       <= '0;
            mul_hi      <= '0;
            mul_neg     <= 1'b0;
`endif
        end else begin
            done_q <= fin;
            if (fin) begin
                result_q <= fin_lo;
                zero_q   <= (fin_lo == '0);
                ovf_q    <= fin_ovf;
`ifdef ALU_EXEC_MUL_EN
                result_hi_q <= fin_hi;
`endif
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r <= dec_op;
                        work <= bus.operand_a;
                        cnt  <= CNT_W'(bus.shamt);
`ifdef ALU_EXEC_MUL_EN
                        if (dec_op == OP_MUL) begin
                            work    <= mag_b;
                            cnt     <= CNT_W'(WIDTH);
                            mul_a   <= mag_a;
                            mul_hi  <= '0;
                            mul_neg <= bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
                        end
`endif
                    end
                end
                SHIFT: begin
                    work <= sh_val;
                    cnt  <= cnt - CNT_W'(1);
                end
`ifdef ALU_EXEC_MUL_EN
                // One multiplier bit per cycle; the extra cycle at cnt==0
                // applies the sign correction.
                MUL: begin
                    if (cnt != '0) begin
                        {mul_hi, work} <= {mul_sum, work[WIDTH-1:1]};
                        cnt            <= cnt - CNT_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
`ifdef ALU_EXEC_MUL_EN
    assign bus.result_hi = result_hi_q;
`else
    assign bus.result_hi = '0;
`endif

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised ALU execute stage: decodes `alu_operation` and the R-format `function_code` internally, then executes with registered results. Single-cycle ops finish in one cycle; shifts run one bit per cycle and the optional multiply runs as an iterative shift-add. A start/busy/done handshake lets the multi-cycle control FSM stall on long operations. It sits in the EX stage, taking operands from the register file/immediate mux and feeding the result to writeback and the branch logic (`zero`).

## Interface
- `WIDTH`, 32, datapath width in bits; must be ≥ 8.
- `SHW`, 5, shift-amount width; `2**SHW` must be ≥ `WIDTH`.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; accepted only when `busy`=0.
- `alu_operation` in 3: class code from main control.
- `function_code` in 6: R-format funct field.
- `operand_a` in WIDTH: rs value.
- `operand_b` in WIDTH: rt value or immediate.
- `shamt` in SHW: shift amount.
- `busy` out 1: a multi-cycle operation is in progress.
- `done` out 1: one-cycle pulse; `result` and flags are valid.
- `result` out WIDTH: low result, held until the next `done`.
- `result_hi` out WIDTH: high half of a multiply; 0 for other ops.
- `zero` out 1: `result` == 0, registered with `result`.
- `overflow` out 1: signed overflow on add/sub, else 0.

## Operation
- Decode, sampled at accept:
  - `alu_operation` 000 or 100 → add.
  - 001 → sub.
  - 101 → and.
  - 111 → or.
  - 011 or 110 → add.
  - 010 → decode funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 1 or 0), 000000 sll, 000010 srl, 000011 sra (new), 011000 mult (signed, feature-gated), any other → add.
- All operands, `shamt` and the decoded op are captured in internal registers at accept. Input changes after accept have no effect.
- FSM states: IDLE, SHIFT, MUL.
- IDLE:
  - On `start`, single-cycle ops (add, sub, and, or, slt) compute immediately. `result`/flags load at the next edge, `done`=1, and the FSM stays in IDLE.
  - Shift with `shamt`=0: same as single-cycle, `result`=`operand_a`.
  - Shift with `shamt`≠0: go to SHIFT, `busy`=1.
  - mult: go to MUL, `busy`=1.
- SHIFT:
  - Shift the working register by 1 bit per cycle and decrement the counter.
  - At count 0: load `result`, pulse `done`, drop `busy`, return to IDLE.
  - sra replicates the MSB; srl and sll fill with 0.
  - `shamt` ≥ `WIDTH` is legal: sll/srl give 0; sra gives all copies of the sign bit.
- MUL:
  - Signed shift-add over `WIDTH` iterations on magnitudes, then sign correction.
  - Loads `{result_hi,result}` = full 2·WIDTH signed product, pulses `done`, returns to IDLE.
- Arithmetic wraps modulo 2^WIDTH.
- `overflow` = sign(a) == sign(±b) and sign(result) ≠ sign(a), for add/sub only.
- `start` while `busy`=1 is ignored; it is not queued.
- `start` held high in IDLE issues back-to-back operations, one per accept.

## Timing
- Reset: `busy`=0, `done`=0, `result`=0, `result_hi`=0, `zero`=1, `overflow`=0, FSM in IDLE, counter=0.
- Reset mid-operation aborts the operation with no `done` pulse.
- Accept at edge N:
  - Single-cycle op: `done` high in cycle N+1.
  - Shift by k (1 ≤ k): `busy` high for cycles N+1..N+k; `done` in cycle N+k+1, same cycle `busy` falls.
  - mult: `busy` high for `WIDTH`+1 cycles; `done` in cycle N+`WIDTH`+2.
- A new `start` is accepted in the `done` cycle of a multi-cycle op, since `busy` is already 0 there.
- `result`, `result_hi`, `zero` and `overflow` change only in `done` cycles.

## Configuration
- `ALU_EXEC_MUL_EN` defined:
  - Funct 011000 performs mult via the MUL state.
  - `result_hi` is driven by the product.
- `ALU_EXEC_MUL_EN` undefined:
  - MUL state and multiplier datapath are not compiled.
  - Funct 011000 falls to the default add, single-cycle.
  - `result_hi` is constant 0.

## Test plan
- Reset then op 010, funct 100010, a=5, b=7 → `done` at N+1, `result`=32'hFFFFFFFE, `zero`=0, `overflow`=0. Then a=32'h7FFFFFFF, b=32'hFFFFFFFF (sub) → `overflow`=1.
- Op 010, funct 000011, a=32'h80000010, shamt=4 → `busy` for 4 cycles, `done` at N+5, `result`=32'hF8000001. Repeat with shamt=0 → `done` at N+1, `result`=a.
- With `ALU_EXEC_MUL_EN`: mult a=−3, b=7 → `done` at N+34, `result`=32'hFFFFFFEB, `result_hi`=32'hFFFFFFFF. Without the macro: same stimulus → `done` at N+1, `result`=4.
- During an sll of shamt 10, pulse `start` with an add at cycle N+3 → it is ignored; exactly one `done`, at N+11, with the shift result.
- Assert `reset` at N+2 of a shamt-8 shift → no `done`; the next cycle shows all reset values and a fresh add completes normally.
- Op 101 and op 111 with a=32'hF0F0, b=32'h0FF0; op 010 funct 101010 with a=−1, b=1 → `result` 32'h00F0, then 32'hFFF0, then 1.
